// File: rtl/isa_regfile_pkg.sv
// Register map, STATUS/CLEAR bit positions and names shared by the ISA command bank.
// Optional response interrupt is enabled with ISA_CMD_REGFILE_IRQ_EN.
package isa_regfile_pkg;

  localparam logic [2:0] REG_ADDR   = 3'd0;
  localparam logic [2:0] REG_DATA   = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_GO     = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_RESULT = 3'd5;
  localparam logic [2:0] REG_CLEAR  = 3'd6;
  localparam logic [2:0] REG_IRQ    = 3'd7;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_RDY   = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_INFL  = 4;
  localparam int ST_LEVEL = 8;

  localparam int CLR_OVF   = 0;
  localparam int CLR_FLUSH = 1;

endpackage

// File: rtl/isa_cmd_regfile_cmd_fifo.sv
// Synchronous show-ahead FIFO: head is visible on dout_o whenever not empty.
// Push while full is dropped even if a pop happens in the same cycle.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [LW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign dout_o  = mem_q[rp_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

  // Flush wins over any same-cycle pop or push.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/isa_cmd_regfile.sv
// Bus-mapped staging bank for ISA cycles: ADDR/DATA/CTRL + GO into a command queue.
// Define ISA_CMD_REGFILE_IRQ_EN to enable the response interrupt at offset 7.
module isa_cmd_regfile
  import isa_regfile_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              read,
  output logic [31:0]       readdata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  output logic [CTRL_W-1:0] cmd_ctrl,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              irq
);

  localparam int W  = ADDR_W + DATA_W + CTRL_W;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, result_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              rdy_q, ovf_q, infl_q;
  logic [31:0]       readdata_q, rd_d;
  logic [W-1:0]      head;
  logic              full, empty, pop, push, flush;
  logic [LW-1:0]     level;
  logic              wr_addr, wr_data, wr_ctrl, wr_clr, rd_res;
  logic              unused_wd;

  assign wr_addr = write && address == REG_ADDR;
  assign wr_data = write && address == REG_DATA;
  assign wr_ctrl = write && address == REG_CTRL;
  assign wr_clr  = write && address == REG_CLEAR;
  assign push    = write && address == REG_GO;
  assign rd_res  = read && address == REG_RESULT;
  assign flush   = wr_clr && writedata[CLR_FLUSH];
  assign pop     = cmd_valid && cmd_ready;

  cmd_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   ({addr_q, data_q, ctrl_q}),
    .pop_i   (pop),
    .flush_i (flush),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign cmd_valid = ~empty;
  assign cmd_addr  = head[W-1 -: ADDR_W];
  assign cmd_data  = head[CTRL_W +: DATA_W];
  assign cmd_ctrl  = head[CTRL_W-1:0];
  assign readdata  = readdata_q;
  assign unused_wd = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      rdy_q    <= 1'b0;
      ovf_q    <= 1'b0;
      infl_q   <= 1'b0;
    end else begin
      if (wr_addr) addr_q <= writedata[ADDR_W-1:0];
      if (wr_data) data_q <= writedata[DATA_W-1:0];
      if (wr_ctrl) ctrl_q <= writedata[CTRL_W-1:0];
      if (push && full) ovf_q <= 1'b1;
      else if (wr_clr && writedata[CLR_OVF]) ovf_q <= 1'b0;
      if (pop) infl_q <= 1'b1;
      else if (rsp_valid) infl_q <= 1'b0;
      // A response landing on a RESULT read keeps RDY for the new data.
      if (rsp_valid) begin
        result_q <= rsp_data;
        rdy_q    <= 1'b1;
      end else if (rd_res) begin
        rdy_q <= 1'b0;
      end
    end
  end

`ifdef ISA_CMD_REGFILE_IRQ_EN
  logic ien_q, irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ien_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (write && address == REG_IRQ) ien_q <= writedata[0];
      irq_q <= ien_q & rdy_q;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_d = '0;
    case (address)
      REG_ADDR:   rd_d[ADDR_W-1:0] = addr_q;
      REG_DATA:   rd_d[DATA_W-1:0] = data_q;
      REG_CTRL:   rd_d[CTRL_W-1:0] = ctrl_q;
      REG_RESULT: rd_d[DATA_W-1:0] = result_q;
      REG_STATUS: begin
        rd_d[ST_BUSY]       = ~empty | infl_q;
        rd_d[ST_FULL]       = full;
        rd_d[ST_RDY]        = rdy_q;
        rd_d[ST_OVF]        = ovf_q;
        rd_d[ST_INFL]       = infl_q;
        rd_d[ST_LEVEL +: LW] = level;
      end
`ifdef ISA_CMD_REGFILE_IRQ_EN
      REG_IRQ:    rd_d[0] = ien_q;
`endif
      default:    rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)     readdata_q <= '0;
    else if (read) readdata_q <= rd_d;
    else           readdata_q <= '0;
  end

endmodule

// File: tb/tb_isa_cmd_regfile.sv
// Scoreboard bench for isa_cmd_regfile: queued commands checked at the handshake.
module tb_isa_cmd_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        write, read;
  logic [31:0] writedata, readdata;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_addr, cmd_data;
  logic [7:0]  cmd_ctrl;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        irq;

  int pass_cnt = 0;
  int total    = 0;

  logic [39:0] exp_q [$];

  always #5 clk = ~clk;

  isa_cmd_regfile dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .read      (read),
    .readdata  (readdata),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_ctrl  (cmd_ctrl),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .irq       (irq)
  );

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic rsp(input logic [15:0] d);
    @(negedge clk);
    rsp_valid = 1'b1; rsp_data = d;
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  task automatic go(input logic [15:0] a, input logic [15:0] d,
                    input logic [7:0] c);
    wr(3'd0, {16'h0, a});
    wr(3'd1, {16'h0, d});
    wr(3'd2, {24'h0, c});
    wr(3'd3, 32'hFFFF_FFFF);
    exp_q.push_back({a, d, c});
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(i[2:0], v);
      total++;
      if (v !== 32'h0) $display("FAIL reset_rd%0d got %h want 0", i, v);
      else pass_cnt++;
    end
    total++;
    if (cmd_valid !== 1'b0 || irq !== 1'b0)
      $display("FAIL reset_out got v=%b irq=%b want 0 0", cmd_valid, irq);
    else pass_cnt++;
  endtask

  task automatic test_go();
    logic [31:0] v;
    wr(3'd0, 32'hDEAD_0220);
    rd(3'd0, v);
    total++;
    if (v !== 32'h0000_0220) $display("FAIL addr_mask got %h want 00000220", v);
    else pass_cnt++;
    go(16'h0220, 16'h00AB, 8'h05);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cmd_valid !== 1'b1 || {cmd_addr, cmd_data, cmd_ctrl} !== exp_q[0])
        $display("FAIL go_hold%0d got %b %h want 1 %h", i, cmd_valid,
                 {cmd_addr, cmd_data, cmd_ctrl}, exp_q[0]);
      else pass_cnt++;
      @(negedge clk);
    end
    rd(3'd4, v);
    total++;
    if (v !== 32'h0101) $display("FAIL go_status got %h want 00000101", v);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    wr(3'd6, 32'h2);
    exp_q.delete();
    for (int i = 0; i < 5; i++) go(16'h0300 + 16'(i), 16'h0010 + 16'(i), 8'(i));
    exp_q.pop_back();
    rd(3'd4, v);
    total++;
    if (v !== 32'h040B) $display("FAIL ovf_status got %h want 0000040b", v);
    else pass_cnt++;
    total++;
    if ({cmd_addr, cmd_data, cmd_ctrl} !== exp_q[0])
      $display("FAIL ovf_head got %h want %h", {cmd_addr, cmd_data, cmd_ctrl}, exp_q[0]);
    else pass_cnt++;
    wr(3'd6, 32'h1);
    rd(3'd4, v);
    total++;
    if (v !== 32'h0403) $display("FAIL ovf_clear got %h want 00000403", v);
    else pass_cnt++;
    wr(3'd6, 32'h2);
    exp_q.delete();
    total++;
    if (cmd_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", cmd_valid);
    else pass_cnt++;
    rd(3'd4, v);
    total++;
    if (v !== 32'h0) $display("FAIL flush_status got %h want 0", v);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int budget;
    go(16'h1234, 16'hBEEF, 8'hA5);
    go(16'hFFFF, 16'h0000, 8'hFF);
    go(16'h0001, 16'h8001, 8'h3C);
    @(negedge clk);
    cmd_ready = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      if (cmd_valid) begin
        total++;
        if ({cmd_addr, cmd_data, cmd_ctrl} !== exp_q[0])
          $display("FAIL b2b_cmd got %h want %h", {cmd_addr, cmd_data, cmd_ctrl}, exp_q[0]);
        else pass_cnt++;
        void'(exp_q.pop_front());
      end
      budget++;
      @(negedge clk);
    end
    cmd_ready = 1'b0;
    total++;
    if (exp_q.size() != 0 || cmd_valid !== 1'b0)
      $display("FAIL b2b_drain got left=%0d v=%b want 0 0", exp_q.size(), cmd_valid);
    else pass_cnt++;
    rd(3'd4, v);
    total++;
    if (v !== 32'h0011) $display("FAIL b2b_infl got %h want 00000011", v);
    else pass_cnt++;
    rsp(16'h0);
    rd(3'd5, v);
  endtask

  task automatic test_response();
    logic [31:0] v;
    go(16'h0042, 16'h0007, 8'h01);
    @(negedge clk);
    cmd_ready = 1'b1;
    total++;
    if ({cmd_addr, cmd_data, cmd_ctrl} !== exp_q[0])
      $display("FAIL rsp_cmd got %h want %h", {cmd_addr, cmd_data, cmd_ctrl}, exp_q[0]);
    else pass_cnt++;
    void'(exp_q.pop_front());
    @(negedge clk);
    cmd_ready = 1'b0;
    rd(3'd4, v);
    total++;
    if (v !== 32'h0011) $display("FAIL rsp_infl got %h want 00000011", v);
    else pass_cnt++;
    rsp(16'h5A5A);
    rd(3'd4, v);
    total++;
    if (v !== 32'h0004) $display("FAIL rsp_rdy got %h want 00000004", v);
    else pass_cnt++;
    rd(3'd5, v);
    total++;
    if (v !== 32'h5A5A) $display("FAIL rsp_result got %h want 00005a5a", v);
    else pass_cnt++;
    rd(3'd4, v);
    total++;
    if (v !== 32'h0) $display("FAIL rsp_rdyclr got %h want 0", v);
    else pass_cnt++;
  endtask

  task automatic test_rsp_collision();
    logic [31:0] v;
    rsp(16'h2222);
    @(negedge clk);
    address = 3'd5; read = 1'b1;
    rsp_valid = 1'b1; rsp_data = 16'h1111;
    @(negedge clk);
    read = 1'b0; rsp_valid = 1'b0;
    total++;
    if (readdata !== 32'h2222) $display("FAIL col_old got %h want 00002222", readdata);
    else pass_cnt++;
    rd(3'd4, v);
    total++;
    if (v !== 32'h0004) $display("FAIL col_rdy got %h want 00000004", v);
    else pass_cnt++;
    rd(3'd5, v);
    total++;
    if (v !== 32'h1111) $display("FAIL col_new got %h want 00001111", v);
    else pass_cnt++;
  endtask

  task automatic test_irq();
    logic [31:0] v;
    wr(3'd7, 32'h1);
    rd(3'd7, v);
`ifdef ISA_CMD_REGFILE_IRQ_EN
    total++;
    if (v !== 32'h1) $display("FAIL irq_ien got %h want 1", v);
    else pass_cnt++;
    @(negedge clk);
    rsp_valid = 1'b1; rsp_data = 16'h0F0F;
    @(negedge clk);
    rsp_valid = 1'b0;
    total++;
    if (irq !== 1'b0) $display("FAIL irq_early got %b want 0", irq);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (irq !== 1'b1) $display("FAIL irq_set got %b want 1", irq);
    else pass_cnt++;
    rd(3'd5, v);
    @(negedge clk);
    total++;
    if (irq !== 1'b0) $display("FAIL irq_clr got %b want 0", irq);
    else pass_cnt++;
`else
    total++;
    if (v !== 32'h0) $display("FAIL irq_off_rd got %h want 0", v);
    else pass_cnt++;
    rsp(16'h0F0F);
    repeat (2) @(negedge clk);
    total++;
    if (irq !== 1'b0) $display("FAIL irq_off got %b want 0", irq);
    else pass_cnt++;
    rd(3'd5, v);
`endif
  endtask

  task automatic test_reset_mid();
    go(16'h0777, 16'h0888, 8'h99);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    total++;
    if (cmd_valid !== 1'b0 || readdata !== 32'h0)
      $display("FAIL reset_mid got v=%b rd=%h want 0 0", cmd_valid, readdata);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; address = '0; write = 1'b0; read = 1'b0;
    writedata = '0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    test_reset();
    test_go();
    test_overflow();
    test_back_to_back();
    test_response();
    test_rsp_collision();
    test_irq();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
